// File: rtl/srl_fifo_pkg.sv
// srl_fifo_flow shared package: default widths and counter sizing.
// Imported by the interface, storage and controller.
package srl_fifo_pkg;

    localparam int SRL_DATA_WIDTH = 8;
    localparam int SRL_DEPTH      = 8;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/srl_fifo_flow_if.sv
// srl_fifo_flow stream interface: push/pop handshake plus status.
// master = producer/consumer side, slave = the FIFO.
interface srl_fifo_flow_if
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SRL_DATA_WIDTH,
    parameter int CNT_WIDTH  = cnt_width(SRL_DEPTH)
);

    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic [CNT_WIDTH-1:0]  if_count;
    logic                  if_almost_full;
    logic                  if_almost_empty;
    logic                  if_overflow;
    logic                  if_underflow;

    modport master (
        output if_write, if_din, if_read,
        input  if_full_n, if_dout, if_empty_n, if_count,
        input  if_almost_full, if_almost_empty,
        input  if_overflow, if_underflow
    );

    modport slave (
        input  if_write, if_din, if_read,
        output if_full_n, if_dout, if_empty_n, if_count,
        output if_almost_full, if_almost_empty,
        output if_overflow, if_underflow
    );

endinterface

// File: rtl/srl_fifo_flow_shift_reg.sv
// srl_fifo_flow storage: unreset shift chain with one enable and an
// address read mux, kept alone so SRL inference stays clean.
module srl_fifo_flow_shift_reg
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SRL_DATA_WIDTH,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = SRL_DEPTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Out-of-range addresses only occur while empty, where dout is unused.
    assign dout = (int'(addr) < DEPTH) ? mem[addr] : mem[0];

endmodule

// File: rtl/srl_fifo_flow.sv
// srl_fifo_flow: shift-register FIFO controller with registered flags.
// Optional sticky error flags: define SRL_FIFO_FLOW_ERR_FLAGS_EN.
module srl_fifo_flow
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SRL_DATA_WIDTH,
    parameter int DEPTH      = SRL_DEPTH,
    parameter int CNT_WIDTH  = cnt_width(DEPTH),
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    srl_fifo_flow_if.slave io
);

    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] FULL_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_C   = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_C   = CNT_WIDTH'(AE_THRESH);

    logic                  push;
    logic                  pop;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  full_n_q;
    logic                  empty_n_q;
    logic                  af_q;
    logic                  ae_q;

    always_comb begin
        push    = io.if_write & full_n_q;
        pop     = io.if_read & empty_n_q;
        cnt_nxt = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        rd_addr = ADDR_WIDTH'(cnt_q - CNT_WIDTH'(1));
    end

    // Flags derive from the next count so they track it with no lag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            af_q      <= (AF_THRESH == 0);
            ae_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_nxt;
            full_n_q  <= (cnt_nxt != FULL_C);
            empty_n_q <= (cnt_nxt != '0);
            af_q      <= (cnt_nxt >= AF_C);
            ae_q      <= (cnt_nxt <= AE_C);
        end
    end

    srl_fifo_flow_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .addr (rd_addr),
        .din  (io.if_din),
        .dout (io.if_dout)
    );

    assign io.if_full_n       = full_n_q;
    assign io.if_empty_n      = empty_n_q;
    assign io.if_count        = cnt_q;
    assign io.if_almost_full  = af_q;
    assign io.if_almost_empty = ae_q;

`ifdef SRL_FIFO_FLOW_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (io.if_write & ~full_n_q) ovf_q <= 1'b1;
            if (io.if_read & ~empty_n_q) udf_q <= 1'b1;
        end
    end

    assign io.if_overflow  = ovf_q;
    assign io.if_underflow = udf_q;
`else
    assign io.if_overflow  = 1'b0;
    assign io.if_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_srl_fifo_flow.sv
// srl_fifo_flow bench: DEPTH=8 and DEPTH=1 instances against a
// queue-based reference model.
module tb_srl_fifo_flow;

    logic clk = 1'b0;
    logic rst_n;
    logic rst1_n;

    always #5 clk = ~clk;

    srl_fifo_flow_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) io8 ();
    srl_fifo_flow_if #(.DATA_WIDTH(8), .CNT_WIDTH(1)) io1 ();

    srl_fifo_flow #(
        .DATA_WIDTH (8),
        .DEPTH      (8)
    ) u8 (
        .clk     (clk),
        .reset_n (rst_n),
        .io      (io8)
    );

    srl_fifo_flow #(
        .DATA_WIDTH (8),
        .DEPTH      (1),
        .CNT_WIDTH  (1),
        .AF_THRESH  (1),
        .AE_THRESH  (0)
    ) u1 (
        .clk     (clk),
        .reset_n (rst1_n),
        .io      (io1)
    );

    int nvec = 0;
    int nerr = 0;

    logic [7:0] q8[$];
    logic [7:0] q1[$];
    bit ovf8, udf8, ovf1, udf1;
    bit mpop8, mpop1;
    logic [7:0] mval8, mval1, obs8, obs1;

    function automatic logic [9:0] exp8();
        return {4'(q8.size()), q8.size() != 8, q8.size() != 0,
                q8.size() >= 7, q8.size() <= 1, ovf8, udf8};
    endfunction

    function automatic logic [9:0] act8();
        return {io8.if_count, io8.if_full_n, io8.if_empty_n,
                io8.if_almost_full, io8.if_almost_empty,
                io8.if_overflow, io8.if_underflow};
    endfunction

    function automatic logic [6:0] exp1();
        return {1'(q1.size()), q1.size() != 1, q1.size() != 0,
                q1.size() >= 1, q1.size() == 0, ovf1, udf1};
    endfunction

    function automatic logic [6:0] act1();
        return {io1.if_count, io1.if_full_n, io1.if_empty_n,
                io1.if_almost_full, io1.if_almost_empty,
                io1.if_overflow, io1.if_underflow};
    endfunction

    // Drive one cycle on the DEPTH=8 port and advance the model.
    task automatic step8(input bit w, input logic [7:0] d, input bit r);
        bit push;
        io8.if_write = w;
        io8.if_din   = d;
        io8.if_read  = r;
        #1;
        obs8  = io8.if_dout;
        push  = w && q8.size() < 8;
        mpop8 = r && q8.size() > 0;
        mval8 = mpop8 ? q8[0] : 8'h00;
`ifdef SRL_FIFO_FLOW_ERR_FLAGS_EN
        if (w && q8.size() == 8) ovf8 = 1'b1;
        if (r && q8.size() == 0) udf8 = 1'b1;
`endif
        if (mpop8) void'(q8.pop_front());
        if (push) q8.push_back(d);
        @(posedge clk);
        #1;
        io8.if_write = 1'b0;
        io8.if_read  = 1'b0;
    endtask

    task automatic step1(input bit w, input logic [7:0] d, input bit r);
        bit push;
        io1.if_write = w;
        io1.if_din   = d;
        io1.if_read  = r;
        #1;
        obs1  = io1.if_dout;
        push  = w && q1.size() < 1;
        mpop1 = r && q1.size() > 0;
        mval1 = mpop1 ? q1[0] : 8'h00;
`ifdef SRL_FIFO_FLOW_ERR_FLAGS_EN
        if (w && q1.size() == 1) ovf1 = 1'b1;
        if (r && q1.size() == 0) udf1 = 1'b1;
`endif
        if (mpop1) void'(q1.pop_front());
        if (push) q1.push_back(d);
        @(posedge clk);
        #1;
        io1.if_write = 1'b0;
        io1.if_read  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        io8.if_write = 1'b1;
        io8.if_din   = 8'h5a;
        repeat (3) @(posedge clk);
        #1;
        q8.delete(); ovf8 = 0; udf8 = 0;
        q1.delete(); ovf1 = 0; udf1 = 0;
        nvec++;
        if (act8() !== exp8()) begin
            nerr++;
            $display("FAIL reset_hold: got %h want %h", act8(), exp8());
        end
        nvec++;
        if (act1() !== exp1()) begin
            nerr++;
            $display("FAIL reset_hold1: got %h want %h", act1(), exp1());
        end
        io8.if_write = 1'b0;
        rst_n  = 1'b1;
        rst1_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step8(1'b0, 8'h00, 1'b0);
            nvec++;
            if (act8() !== exp8()) begin
                nerr++;
                $display("FAIL idle[%0d]: got %h want %h", i, act8(), exp8());
            end
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            step8(1'b1, 8'(8'h11 + i), 1'b0);
            nvec++;
            if (act8() !== exp8()) begin
                nerr++;
                $display("FAIL fill[%0d]: got %h want %h", i, act8(), exp8());
            end
        end
        for (int i = 0; i < 8; i++) begin
            step8(1'b0, 8'h00, 1'b1);
            nvec++;
            if (obs8 !== 8'(8'h11 + i)) begin
                nerr++;
                $display("FAIL drain_data[%0d]: got %h want %h",
                         i, obs8, 8'(8'h11 + i));
            end
            nvec++;
            if (act8() !== exp8()) begin
                nerr++;
                $display("FAIL drain[%0d]: got %h want %h", i, act8(), exp8());
            end
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 8; i++) step8(1'b1, 8'(8'h11 + i), 1'b0);
        step8(1'b1, 8'hAA, 1'b1);
        nvec++;
        if (obs8 !== 8'h11 || !mpop8) begin
            nerr++;
            $display("FAIL full_simul_pop: got %h want 11", obs8);
        end
        nvec++;
        if (act8() !== exp8()) begin
            nerr++;
            $display("FAIL full_simul: got %h want %h", act8(), exp8());
        end
        for (int i = 0; i < 7; i++) begin
            step8(1'b0, 8'h00, 1'b1);
            nvec++;
            if (obs8 !== mval8) begin
                nerr++;
                $display("FAIL full_simul_drain[%0d]: got %h want %h",
                         i, obs8, mval8);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] base;
        base = 8'($urandom);
        for (int i = 0; i < 3; i++) step8(1'b1, 8'(base + i), 1'b0);
        for (int i = 3; i < 103; i++) begin
            step8(1'b1, 8'(base + i), 1'b1);
            nvec++;
            if (obs8 !== 8'(base + i - 3) || act8() !== exp8()) begin
                nerr++;
                $display("FAIL stream[%0d]: got %h/%h want %h/%h", i,
                         obs8, act8(), 8'(base + i - 3), exp8());
            end
        end
        for (int i = 0; i < 3; i++) step8(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step8(1'($urandom), 8'($urandom), 1'($urandom));
            nvec++;
            if ((mpop8 && obs8 !== mval8) || act8() !== exp8()) begin
                nerr++;
                $display("FAIL random[%0d]: got %h/%h want %h/%h", i,
                         obs8, act8(), mval8, exp8());
            end
        end
        for (int i = 0; i < 9; i++) step8(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_err_flags();
        rst_n = 1'b0;
        #1;
        q8.delete(); ovf8 = 0; udf8 = 0;
        rst_n = 1'b1;
        step8(1'b0, 8'h00, 1'b1);
        nvec++;
        if (act8() !== exp8()) begin
            nerr++;
            $display("FAIL underflow: got %h want %h", act8(), exp8());
        end
        for (int i = 0; i < 8; i++) step8(1'b1, 8'(i), 1'b0);
        step8(1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step8(1'b0, 8'h00, 1'b0);
            nvec++;
            if (act8() !== exp8()) begin
                nerr++;
                $display("FAIL overflow_hold[%0d]: got %h want %h",
                         i, act8(), exp8());
            end
        end
    endtask

    task automatic test_depth1();
        for (int i = 0; i < 20; i++) begin
            step1(i % 2 == 0, 8'($urandom), i % 2 == 1);
            nvec++;
            if ((mpop1 && obs1 !== mval1) || act1() !== exp1()
                || io1.if_full_n === io1.if_empty_n) begin
                nerr++;
                $display("FAIL depth1[%0d]: got %h/%h want %h/%h", i,
                         obs1, act1(), mval1, exp1());
            end
        end
        step1(1'b1, 8'h3C, 1'b0);
        nvec++;
        if (act1() !== exp1()) begin
            nerr++;
            $display("FAIL depth1_load: got %h want %h", act1(), exp1());
        end
        #2;
        rst1_n = 1'b0;
        #1;
        q1.delete(); ovf1 = 0; udf1 = 0;
        nvec++;
        if (act1() !== exp1()) begin
            nerr++;
            $display("FAIL async_reset: got %h want %h", act1(), exp1());
        end
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step1(1'($urandom), 8'($urandom), 1'($urandom));
            nvec++;
            if ((mpop1 && obs1 !== mval1) || act1() !== exp1()) begin
                nerr++;
                $display("FAIL depth1_after[%0d]: got %h/%h want %h/%h", i,
                         obs1, act1(), mval1, exp1());
            end
        end
    endtask

    initial begin
        io8.if_write = 1'b0; io8.if_read = 1'b0; io8.if_din = 8'h00;
        io1.if_write = 1'b0; io1.if_read = 1'b0; io1.if_din = 8'h00;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_full_simul();
        test_back_to_back();
        test_random();
        test_err_flags();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/srl_fifo_flow.md
Name: srl_fifo_flow

Overview:
- Parametrised shift-register FIFO. Successor to the fixed 1-bit/8-deep start-token shift register used between dataflow processes.
- Adds a full handshake FIFO controller with registered full/empty, occupancy count, programmable almost-full and almost-empty thresholds, and depth generalisation including DEPTH=1.
- Instantiated between TAPA/HLS dataflow tasks (e.g. PE start/pack streams).
- Storage stays SRL-inferable: no reset on data, one shift enable, read via address mux.

Parameters:
- DATA_WIDTH, 8, payload bits per entry (>=1).
- DEPTH, 8, number of entries (>=1).
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width.
- AF_THRESH, DEPTH-1, if_almost_full asserted when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, if_almost_empty asserted when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_write  in  1  push request.
- if_din  in  DATA_WIDTH  push data.
- if_full_n  out  1  registered; 1 = space available.
- if_read  in  1  pop request.
- if_dout  out  DATA_WIDTH  oldest entry, show-ahead.
- if_empty_n  out  1  registered; 1 = data available.
- if_count  out  CNT_WIDTH  registered occupancy.
- if_almost_full  out  1  registered, count >= AF_THRESH.
- if_almost_empty  out  1  registered, count <= AE_THRESH.
- if_overflow  out  1  sticky error flag (see Optional Feature).
- if_underflow  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync-to-clk deassert by the system):
  - count=0, if_empty_n=0, if_full_n=1, if_almost_empty=1.
  - if_almost_full=(AF_THRESH==0 ? 1 : 0), i.e. 0 for legal values.
  - Error flags 0.
  - Storage not reset.
- Accept rules:
  - push = if_write & if_full_n.
  - pop = if_read & if_empty_n.
  - Rejected requests have no effect on state.
- Storage:
  - On push, all entries shift by one and din enters slot 0.
  - if_dout = slot[count-1], combinational from registered count.
  - When count==0, if_dout is don't-care; the bench must not check it.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. The shift occurs and the new oldest entry appears at the same address next cycle.
- Flags are registered from next-count:
  - if_full_n = (next != DEPTH).
  - if_empty_n = (next != 0).
  - Thresholds are compared the same way.
  - Zero extra latency relative to count.
- Latency:
  - Write-to-read: an entry pushed at edge N is visible on if_dout, with if_empty_n=1, after edge N (cycle N+1).
  - Pop-to-space: one cycle.
- Boundaries:
  - Full with push and pop together: the push is rejected (if_full_n=0), the pop proceeds, count becomes DEPTH-1.
  - Empty with push and pop together: the pop is rejected, count becomes 1.
  - DEPTH=1: acts as a one-entry register slice, with full_n/empty_n complementary.
  - Reset mid-stream: contents are lost logically (count=0) regardless of storage values.

Optional Feature:
- Macro: SRL_FIFO_FLOW_ERR_FLAGS_EN.
- Defined:
  - if_overflow sets sticky on the first cycle with if_write=1 and if_full_n=0.
  - if_underflow sets sticky on the first cycle with if_read=1 and if_empty_n=0.
  - Both clear only on reset.
- Undefined: both ports are driven constant 0 and no logic is generated. Port list is identical in both builds.

Decomposition:
- Package srl_fifo_pkg holds:
  - function cnt_width(depth) returning $clog2(depth+1).
  - localparam defaults shared by stream wrappers.
- Sub-module srl_fifo_flow_shift_reg: the storage only (clk, we, addr, din, dout, DATA_WIDTH/ADDR_WIDTH/DEPTH). Keeps SRL inference isolated.
- Controller logic lives in the top.

Test Plan:
- Reset/idle: DEPTH=8, DATA_WIDTH=8. Hold reset_n=0 and assert if_write -> if_full_n=1, if_empty_n=0, count=0. After release with no requests, all state is stable.
- Fill/drain order:
  - Push 0x11..0x18 on consecutive cycles -> count=8, if_full_n=0, if_almost_full=1 from count 7.
  - Pop 8 -> if_dout sequence 0x11..0x18, then if_empty_n=0, if_almost_empty=1 at count<=1.
- Simultaneous at full: fill to 8, assert push(0xAA) and pop together -> 0x11 popped, 0xAA discarded, count=7.
- Steady streaming: count=3, push and pop every cycle for 100 cycles with an incrementing pattern -> count stays 3, output equals input delayed by 3 accepts, no loss.
- DEPTH=1 plus async reset mid-stream:
  - Alternate push/pop -> full_n = !empty_n every cycle.
  - Assert reset_n=0 mid-cycle with count=1 -> flags return to reset values immediately, without waiting for a clock edge.
- Err flags (macro defined): push when full -> if_overflow=1 next cycle and held; pop when empty -> if_underflow=1. Macro undefined -> both remain 0.
